// File: rtl/semafor_directie_param.sv
// Lamp controller for one intersection approach: red-clearance, green with
// demand extension, yellow, then a one-clock ready pulse; flashing yellow in blink phase.
module semafor_directie_param #(
  parameter int                 PHASE_W     = 3,
  parameter logic [PHASE_W-1:0] MY_PHASE    = 3'b011,
  parameter logic [PHASE_W-1:0] BLINK_PHASE = 3'b111,
  parameter int                 CNT_W       = 6,
  parameter int                 T_RED_CLR   = 1,
  parameter int                 T_GREEN     = 23,
  parameter int                 T_GREEN_MAX = 40,
  parameter int                 T_YELLOW    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] stare_semafor,
  input  logic               tick,
  input  logic               blink,
  input  logic               ext_req,
  output logic               ready,
  output logic               verde,
  output logic               galben,
  output logic               rosu,
  output logic [2:0]         stare_dbg
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] RED_CLR = 3'd1;
  localparam logic [2:0] GREEN   = 3'd2;
  localparam logic [2:0] YELLOW  = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;
  localparam logic [2:0] BLINK   = 3'd5;

  localparam logic [CNT_W-1:0] RC_END   = CNT_W'(T_RED_CLR - 1);
  localparam logic [CNT_W-1:0] G_END    = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] GMAX_END = CNT_W'(T_GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] Y_END    = CNT_W'(T_YELLOW - 1);

  logic [2:0]       state, nxt_state;
  logic [CNT_W-1:0] cnt, nxt_cnt;
  logic             nxt_ready;

  // Phase decode takes precedence over tick so an abort never lets a tick through.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_ready = 1'b0;
    if (stare_semafor == BLINK_PHASE) begin
      nxt_state = BLINK;
      nxt_cnt   = '0;
    end else if (stare_semafor != MY_PHASE) begin
      nxt_state = IDLE;
      nxt_cnt   = '0;
    end else if (state == IDLE || state > DONE) begin
      nxt_state = RED_CLR;
      nxt_cnt   = '0;
    end else if (tick) begin
      case (state)
        RED_CLR: begin
          if (cnt == RC_END) begin
            nxt_state = GREEN;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        GREEN: begin
          if (cnt == GMAX_END || (cnt >= G_END && !ext_req)) begin
            nxt_state = YELLOW;
            nxt_cnt   = '0;
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        YELLOW: begin
          if (cnt == Y_END) begin
            nxt_state = DONE;
            nxt_cnt   = '0;
            nxt_ready = 1'b1;
          end else begin
            nxt_cnt = cnt + 1'b1;
          end
        end
        default: begin
          nxt_state = state;
          nxt_cnt   = cnt;
        end
      endcase
    end
  end

  // Lamps are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      ready  <= 1'b0;
      rosu   <= 1'b1;
      verde  <= 1'b0;
      galben <= 1'b0;
    end else begin
      state  <= nxt_state;
      cnt    <= nxt_cnt;
      ready  <= nxt_ready;
      rosu   <= (nxt_state == IDLE) || (nxt_state == RED_CLR) || (nxt_state == DONE);
      verde  <= (nxt_state == GREEN);
      galben <= (nxt_state == YELLOW) || (nxt_state == BLINK && blink);
    end
  end

  assign stare_dbg = state;

endmodule

// File: tb/tb_semafor_directie_param.sv
// Bench for semafor_directie_param: tick-count reference model compared every cycle,
// directed scenarios with literal lamp-duration checks, then randomized traffic.
module tb_semafor_directie_param;

  localparam int T_RED_CLR   = 1;
  localparam int T_GREEN     = 23;
  localparam int T_GREEN_MAX = 40;
  localparam int T_YELLOW    = 2;
  localparam logic [2:0] MP  = 3'b011;
  localparam logic [2:0] BP  = 3'b111;

  localparam int M_IDLE  = 0;
  localparam int M_GRANT = 1;
  localparam int M_BLINK = 2;

  logic       clk = 1'b0;
  logic       rst, tick, blink, ext_req;
  logic [2:0] phase;
  logic       ready, verde, galben, rosu;
  logic [2:0] stare_dbg;

  always #5 clk = ~clk;

  semafor_directie_param dut (
    .clk(clk), .rst(rst), .stare_semafor(phase), .tick(tick), .blink(blink),
    .ext_req(ext_req), .ready(ready), .verde(verde), .galben(galben),
    .rosu(rosu), .stare_dbg(stare_dbg)
  );

  // Model: ticks counted since grant (k) and the tick count at which green ended (gend).
  int   mode = M_IDLE;
  int   k = 0;
  int   gend = -1;
  int   g;
  logic exp_blk = 1'b0;
  logic exp_ready = 1'b0;
  bit   model_valid = 1'b0;

  always @(posedge clk) begin
    exp_ready = 1'b0;
    if (rst) mode = M_IDLE;
    else if (phase == BP) begin
      mode    = M_BLINK;
      exp_blk = blink;
    end else if (phase != MP) mode = M_IDLE;
    else if (mode != M_GRANT) begin
      mode = M_GRANT;
      k    = 0;
      gend = -1;
    end else if (tick && !(gend >= 0 && k >= gend + T_YELLOW)) begin
      if (gend < 0 && k >= T_RED_CLR) begin
        g = k - T_RED_CLR;
        if (g >= T_GREEN - 1 && (!ext_req || g == T_GREEN_MAX - 1)) gend = k + 1;
      end
      k++;
      if (gend >= 0 && k == gend + T_YELLOW) exp_ready = 1'b1;
    end
    model_valid = 1'b1;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int cnt_v = 0, cnt_y = 0, cnt_r = 0, cnt_rdy = 0;
  int sv, sy, sr, srd, n;
  logic t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic cycle(input logic tk);
    int e_r, e_v, e_y, e_d;
    @(negedge clk);
    if (model_valid) begin
      e_r = 0; e_v = 0; e_y = 0; e_d = 0;
      if (mode == M_IDLE) e_r = 1;
      else if (mode == M_BLINK) begin
        e_y = int'(exp_blk);
        e_d = 5;
      end else if (k < T_RED_CLR) begin
        e_r = 1; e_d = 1;
      end else if (gend < 0 || k < gend) begin
        e_v = 1; e_d = 2;
      end else if (k < gend + T_YELLOW) begin
        e_y = 1; e_d = 3;
      end else begin
        e_r = 1; e_d = 4;
      end
      chk("rosu", int'(rosu), e_r);
      chk("verde", int'(verde), e_v);
      chk("galben", int'(galben), e_y);
      chk("stare_dbg", int'(stare_dbg), e_d);
      chk("ready", int'(ready), int'(exp_ready));
    end
    cnt_v   += int'(verde);
    cnt_y   += int'(galben);
    cnt_r   += int'(rosu);
    cnt_rdy += int'(ready);
    tick = tk;
  endtask

  task automatic ptick();
    cycle((cyc % 4) == 0);
    cyc++;
  endtask

  task automatic snap();
    sv = cnt_v; sy = cnt_y; sr = cnt_r; srd = cnt_rdy;
  endtask

  initial begin
    rst = 1'b1; phase = 3'b000; tick = 1'b0; blink = 1'b0; ext_req = 1'b0;
    cycle(1'b0);
    cycle(1'b0);
    chk("reset_rosu", int'(rosu), 1);
    chk("reset_verde", int'(verde), 0);
    chk("reset_galben", int'(galben), 0);
    chk("reset_ready", int'(ready), 0);
    chk("reset_dbg", int'(stare_dbg), 0);
    rst = 1'b0;
    repeat (4) ptick();

    // Nominal cycle: 23 ticks green, 2 ticks yellow, single ready
    ext_req = 1'b0; phase = MP; snap();
    repeat (130) ptick();
    chk("nom_green_clks", cnt_v - sv, 92);
    chk("nom_yellow_clks", cnt_y - sy, 8);
    chk("nom_ready_pulses", cnt_rdy - srd, 1);
    phase = 3'b000;
    repeat (6) ptick();

    // Extension held: green capped at 40 ticks
    ext_req = 1'b1; phase = MP; snap();
    repeat (200) ptick();
    chk("max_green_clks", cnt_v - sv, 160);
    chk("max_yellow_clks", cnt_y - sy, 8);
    chk("max_ready_pulses", cnt_rdy - srd, 1);
    phase = 3'b000;
    repeat (6) ptick();

    // Extension released on green tick 30
    ext_req = 1'b1; phase = MP; snap(); n = 0;
    repeat (180) begin
      t = (cyc % 4) == 0;
      cycle(t);
      cyc++;
      if (t) begin
        n++;
        if (n == 32) ext_req = 1'b0;
      end
    end
    chk("ext_green_clks", cnt_v - sv, 124);
    chk("ext_ready_pulses", cnt_rdy - srd, 1);
    phase = 3'b000;
    repeat (6) ptick();

    // Abort on green tick 10, coincident with a tick
    ext_req = 1'b0; phase = MP; snap(); n = 0;
    for (int i = 0; i < 100 && n < 12; i++) begin
      t = (cyc % 4) == 0;
      cycle(t);
      cyc++;
      if (t) begin
        n++;
        if (n == 12) phase = 3'b010;
      end
    end
    cycle(1'b0);
    chk("abort_dbg", int'(stare_dbg), 0);
    chk("abort_rosu", int'(rosu), 1);
    repeat (10) ptick();
    chk("abort_ready_pulses", cnt_rdy - srd, 0);
    chk("abort_yellow_clks", cnt_y - sy, 0);

    // Flashing yellow, then re-grant
    phase = BP; blink = 1'b0;
    cycle(1'b0);
    snap();
    for (int i = 0; i < 48; i++) begin
      ptick();
      if (i % 8 == 7) blink = ~blink;
    end
    chk("blink_green_clks", cnt_v - sv, 0);
    chk("blink_red_clks", cnt_r - sr, 0);
    chk("blink_yellow_clks", cnt_y - sy, 24);
    phase = MP;
    cycle(1'b0);
    chk("regrant_dbg", int'(stare_dbg), 1);
    chk("regrant_rosu", int'(rosu), 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 149) == 0) begin
        case ($urandom_range(0, 5))
          0, 1, 2: phase = MP;
          3:       phase = BP;
          4:       phase = 3'b000;
          default: phase = 3'($urandom_range(0, 7));
        endcase
      end
      if ($urandom_range(0, 9) == 0) ext_req = ~ext_req;
      if ($urandom_range(0, 7) == 0) blink = ~blink;
      rst = ($urandom_range(0, 499) == 0);
    end
    rst = 1'b0;
    cycle(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
